// File: rtl/cordic_mult_param.sv
`default_nettype none
// ============================================================================
// Module   : cordic_mult_param
// Purpose  : Sequential linear-mode CORDIC multiplier, y ~= x * z, with one
//            shift-add step per clock. Operands are captured on a start
//            handshake. The operation stops early once the residual reaches
//            zero. The accumulator adder can be switched at run time to a
//            lower-part-OR approximate adder.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_W     operand width; z is read as Q1.(DATA_W-1)
//   ITER       maximum number of CORDIC iterations (1 .. 2*DATA_W)
//   APPROX_LSB low accumulator bits combined by OR in approximate mode
//              (0 makes the adder always exact)
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      request, sampled only in IDLE
//   approx_en  1 = approximate accumulator adder (captured with start)
//   x          signed multiplicand (captured with start)
//   z          signed multiplier code (captured with start)
//   busy       high while iterating
//   done       one-cycle pulse when y/iters become valid
//   y          signed result, saturated to 2*DATA_W bits, held until next done
//   iters      number of iterations performed by the last operation
// ============================================================================
module cordic_mult_param #(
  parameter int DATA_W     = 8,
  parameter int ITER       = 8,
  parameter int APPROX_LSB = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          approx_en,
  input  logic signed [DATA_W-1:0]      x,
  input  logic signed [DATA_W-1:0]      z,
  output logic                          busy,
  output logic                          done,
  output logic signed [2*DATA_W-1:0]    y,
  output logic [$clog2(ITER+1)-1:0]     iters
);

  localparam int ACC_W = 2 * DATA_W + 1;
  localparam int ZR_W  = DATA_W + 1;
  localparam int Y_W   = 2 * DATA_W;
  localparam int IW    = $clog2(ITER + 1);

  localparam logic [IW-1:0]  c_ITER  = IW'(ITER);
  localparam logic [Y_W-1:0] c_Y_MAX = {1'b0, {(Y_W-1){1'b1}}};
  localparam logic [Y_W-1:0] c_Y_MIN = {1'b1, {(Y_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  logic signed [DATA_W-1:0] r_x;
  logic                     r_approx;
  logic signed [ZR_W-1:0]   r_zr;
  logic        [ACC_W-1:0]  r_acc;
  logic        [IW-1:0]     r_i;

  logic signed [ACC_W-1:0]  w_x_ext;
  logic signed [ACC_W-1:0]  w_step;
  logic        [ACC_W-1:0]  w_addend;
  logic        [ACC_W-1:0]  w_sum;
  logic        [ZR_W-1:0]   w_zr_step;
  logic        [ZR_W-1:0]   w_zr_next;
  logic                     w_finish;
  logic                     w_ovf;
  logic        [Y_W-1:0]    w_y_sat;
  int                       w_idx;

  assign w_x_ext = {{(ACC_W-DATA_W){r_x[DATA_W-1]}}, r_x};

  // Step weight 2^(DATA_W-1-i). Once the exponent goes negative the multiplicand
  // is shifted right arithmetically (low bits lost) and the residual no longer
  // moves.
  always_comb begin
    w_step    = '0;
    w_zr_step = '0;
    w_idx     = int'(r_i);
    if (w_idx <= DATA_W - 1) begin
      w_step    = w_x_ext <<< (DATA_W - 1 - w_idx);
      w_zr_step = {{(ZR_W-1){1'b0}}, 1'b1} << (DATA_W - 1 - w_idx);
    end else begin
      w_step    = w_x_ext >>> (w_idx - (DATA_W - 1));
      w_zr_step = '0;
    end
  end

  // Residual sign selects add or subtract of the step (zr >= 0 -> +s).
  assign w_addend  = r_zr[ZR_W-1] ? (-w_step) : w_step;
  assign w_zr_next = r_zr[ZR_W-1] ? (r_zr + w_zr_step) : (r_zr - w_zr_step);

  // Accumulator adder: exact, or OR on the low APPROX_LSB bits with the upper
  // part added without a carry-in from the low part.
  generate
    if (APPROX_LSB == 0) begin : g_exact_only
      assign w_sum = r_acc + w_addend;
    end else begin : g_approx
      logic [ACC_W-1:0]            w_exact;
      logic [ACC_W-APPROX_LSB-1:0] w_hi;
      logic [APPROX_LSB-1:0]       w_lo;
      assign w_exact = r_acc + w_addend;
      assign w_hi    = r_acc[ACC_W-1:APPROX_LSB] + w_addend[ACC_W-1:APPROX_LSB];
      assign w_lo    = r_acc[APPROX_LSB-1:0] | w_addend[APPROX_LSB-1:0];
      assign w_sum   = r_approx ? {w_hi, w_lo} : w_exact;
    end
  endgenerate

  assign w_finish = (r_zr == '0) || (r_i == c_ITER);

  // The accumulator has one guard bit over the result; disagreement between
  // the top two bits means the value does not fit and is clamped.
  assign w_ovf   = r_acc[ACC_W-1] ^ r_acc[ACC_W-2];
  assign w_y_sat = w_ovf ? (r_acc[ACC_W-1] ? c_Y_MIN : c_Y_MAX) : r_acc[Y_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_x      <= '0;
      r_approx <= 1'b0;
      r_zr     <= '0;
      r_acc    <= '0;
      r_i      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      y        <= '0;
      iters    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_x      <= x;
            r_approx <= approx_en;
            r_zr     <= {z[DATA_W-1], z};
            r_acc    <= '0;
            r_i      <= '0;
            busy     <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_finish) begin
            y       <= w_y_sat;
            iters   <= r_i;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_acc <= w_sum;
            r_zr  <= w_zr_next;
            r_i   <= r_i + IW'(1);
          end
        end
        S_DONE: begin
          // start is deliberately not sampled here; it is only seen in IDLE.
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cordic_mult_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_mult_param
// Purpose  : Self-checking bench for cordic_mult_param (DATA_W=8, ITER=8,
//            APPROX_LSB=4): directed vector table, handshake corner cases,
//            and randomized operations against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cordic_mult_param;

  localparam int DATA_W     = 8;
  localparam int ITER       = 8;
  localparam int APPROX_LSB = 4;
  localparam int ACC_W      = 2 * DATA_W + 1;

  logic                     clk;
  logic                     rst_n;
  logic                     start;
  logic                     approx_en;
  logic signed [DATA_W-1:0] x;
  logic signed [DATA_W-1:0] z;
  logic                     busy;
  logic                     done;
  logic signed [2*DATA_W-1:0] y;
  logic [3:0]               iters;

  int checks;
  int failures;
  int done_cnt;
  int start_cnt;

  cordic_mult_param #(
    .DATA_W    (DATA_W),
    .ITER      (ITER),
    .APPROX_LSB(APPROX_LSB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .approx_en(approx_en),
    .x        (x),
    .z        (z),
    .busy     (busy),
    .done     (done),
    .y        (y),
    .iters    (iters)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && done) done_cnt++;
  end

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: iterate the linear CORDIC recurrence with plain integer
  // arithmetic; the accumulator is an ACC_W-bit modular register.
  function automatic void model(input int xi, input int zi, input bit ap,
                                output longint yo, output int n);
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] b;
    logic [ACC_W-1:0] lom;
    longint s;
    longint t;
    int zr;
    int k;
    acc = '0;
    zr  = zi;
    n   = 0;
    lom = ACC_W'((1 << APPROX_LSB) - 1);
    while (zr != 0 && n < ITER) begin
      k = DATA_W - 1 - n;
      if (k >= 0) s = longint'(xi) * (longint'(1) << k);
      else        s = longint'(xi) >>> (-k);
      t = (zr >= 0) ? s : -s;
      b = t[ACC_W-1:0];
      if (ap && APPROX_LSB > 0)
        acc = (((acc >> APPROX_LSB) + (b >> APPROX_LSB)) << APPROX_LSB) | ((acc | b) & lom);
      else
        acc = acc + b;
      if (k >= 0) zr = (zr >= 0) ? zr - (1 << k) : zr + (1 << k);
      n++;
    end
    yo = longint'($signed(acc));
    if (yo > 32767)  yo = 32767;
    if (yo < -32768) yo = -32768;
  endfunction

  // One operation: start at a negedge, the next posedge is E0. Latency is the
  // number of edges after E0 until done is seen. poke>0 pulses start with other
  // operands at that cycle to check it is ignored.
  task automatic run_op(input int xi, input int zi, input bit ap, input int poke,
                        output longint yo, output int it, output int lat);
    int xv;
    int zv;
    xv = xi;
    zv = zi;
    @(negedge clk);
    x = xv[7:0];
    z = zv[7:0];
    approx_en = ap;
    start = 1'b1;
    @(posedge clk);
    start_cnt++;
    #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= ITER + 6; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        chk("busy_at_done", busy, 0);
        break;
      end else if (!busy) begin
        chk("busy_during_run", busy, 1);
      end
      if (poke > 0 && k == poke) begin
        start = 1'b1;
        x = 8'sd50;
        z = 8'sd50;
        approx_en = ~ap;
      end
      if (poke > 0 && k == poke + 1) start = 1'b0;
    end
    if (lat < 0) chk("done_timeout", 0, 1);
    yo = longint'(y);
    it = int'(iters);
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 0);
  endtask

  typedef struct {
    int     x;
    int     z;
    bit     ap;
    longint y;
    int     it;
  } vec_t;

  vec_t tbl[6];

  initial begin
    longint yo;
    longint ey;
    int     it;
    int     lat;
    int     en;
    int     xi;
    int     zi;
    bit     ap;
    bit     saw_done;
    longint err;
    longint ax;

    checks = 0; failures = 0; done_cnt = 0; start_cnt = 0;

    tbl[0] = '{x: 100,  z: 64,   ap: 1'b0, y: 6400,  it: 2};
    tbl[1] = '{x: 1,    z: 127,  ap: 1'b0, y: 127,   it: 8};
    tbl[2] = '{x: -128, z: -128, ap: 1'b0, y: 16384, it: 1};
    tbl[3] = '{x: 5,    z: 0,    ap: 1'b0, y: 0,     it: 0};
    tbl[4] = '{x: 3,    z: 127,  ap: 1'b1, y: 367,   it: 8};
    tbl[5] = '{x: 3,    z: 127,  ap: 1'b0, y: 381,   it: 8};

    rst_n = 1'b0; start = 1'b0; approx_en = 1'b0; x = '0; z = '0;
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_y", y, 0);
    chk("reset_iters", iters, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int v = 0; v < 6; v++) begin
      run_op(tbl[v].x, tbl[v].z, tbl[v].ap, 0, yo, it, lat);
      chk($sformatf("vec%0d_y", v), yo, tbl[v].y);
      chk($sformatf("vec%0d_iters", v), it, tbl[v].it);
      chk($sformatf("vec%0d_latency", v), lat, tbl[v].it + 1);
    end

    // start held high: second capture only after DONE -> IDLE
    @(negedge clk);
    x = 8'sd5; z = 8'sd0; approx_en = 1'b0; start = 1'b1;
    @(posedge clk);
    start_cnt++;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      case (k)
        1: begin chk("hold_done_k1", done, 1); chk("hold_y_k1", y, 0); chk("hold_iters_k1", iters, 0); end
        2: begin chk("hold_done_k2", done, 0); chk("hold_busy_k2", busy, 0); end
        3: begin chk("hold_busy_k3", busy, 1); start_cnt++; end
        4: begin chk("hold_done_k4", done, 1); start = 1'b0; end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    chk("hold_idle_busy", busy, 0);

    // start pulsed during RUN must be ignored
    run_op(1, 127, 1'b0, 3, yo, it, lat);
    chk("poke_y", yo, 127);
    chk("poke_iters", it, 8);
    chk("poke_latency", lat, 9);

    // Reset in the middle of an 8-iteration run
    @(negedge clk);
    x = 8'sd1; z = 8'sd127; approx_en = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_y", y, 0);
    chk("abort_iters", iters, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);
    model(7, -100, 1'b0, ey, en);
    run_op(7, -100, 1'b0, 0, yo, it, lat);
    chk("after_abort_y", yo, ey);
    chk("after_abort_iters", it, en);

    // Randomized: 200 exact, 100 approximate
    for (int r = 0; r < 300; r++) begin
      xi = int'($urandom_range(0, 255)) - 128;
      zi = int'($urandom_range(0, 255)) - 128;
      ap = (r >= 200);
      model(xi, zi, ap, ey, en);
      run_op(xi, zi, ap, 0, yo, it, lat);
      chk("rand_y", yo, ey);
      chk("rand_iters", it, en);
      chk("rand_latency", lat, en + 1);
      if (!ap) begin
        err = yo - longint'(xi) * longint'(zi);
        if (err < 0) err = -err;
        ax = (xi < 0) ? -xi : xi;
        chk("rand_exact_bound", (err <= ax), 1);
      end
    end

    repeat (2) @(posedge clk);
    #1;
    chk("done_count", done_cnt, start_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cordic_mult_param.md
# cordic_mult_param

Parametrised sequential linear-mode CORDIC multiplier. It computes y ≈ x·z for signed DATA_W-bit operands using one shift-add step per clock. It adds three things: a start/busy/done handshake with captured operands, early termination when the residual reaches zero, and a run-time selectable lower-part-OR approximate accumulator adder. It sits in the approximate-arithmetic datapath as the drop-in multiplier for error/energy characterisation sweeps.

## Interface
- DATA_W, 8: operand width. z is read as Q1.(DATA_W-1), i.e. z_real = z/2^(DATA_W-1).
- ITER, 8: maximum CORDIC iterations (1..2·DATA_W).
- APPROX_LSB, 4: number of low accumulator bits summed by bitwise OR when approx mode is on. 0 means the adder is always exact.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- approx_en  in  1  mode select, captured with start. 1 = approximate accumulator adder.
- x  in  DATA_W  signed multiplicand, captured with start.
- z  in  DATA_W  signed multiplier code, captured with start.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when y becomes valid.
- y  out  2·DATA_W  signed result, ≈ x·z (raw integer product). Held until the next done.
- iters  out  clog2(ITER+1)  number of iterations the last operation performed.

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE: on a clock edge with start=1, capture x, z and approx_en. Load residual zr=z (DATA_W+1 bits, signed), accumulator acc=0 (ACC_W=2·DATA_W+1 bits, signed) and index i=0. Go to RUN.
- RUN, at each edge:
  - If zr==0 or i==ITER, go to DONE. y gets acc saturated to the 2·DATA_W signed range; iters gets i. No accumulator update on this edge.
  - Otherwise perform one iteration. The step is s = sign-extended x·2^(DATA_W-1-i) (arithmetic shift; bits shifted below bit 0 are lost).
    - If zr ≥ 0: acc = acc ⊕ s and zr -= 2^(DATA_W-1-i).
    - Else: acc = acc ⊕ (−s) and zr += 2^(DATA_W-1-i).
    - Increment i. When DATA_W-1-i < 0, the zr step is 0.
- DONE: done=1 for exactly one cycle, then unconditionally return to IDLE. start is not accepted in DONE.
- Adder ⊕:
  - −s is the exact two's-complement negation in ACC_W bits.
  - With approx_en=0, or APPROX_LSB=0, ⊕ is exact ACC_W addition, wrapping modulo 2^ACC_W.
  - With approx_en=1: result[APPROX_LSB-1:0] = a|b (bitwise OR). result[ACC_W-1:APPROX_LSB] = upper(a)+upper(b) modulo width, with no carry in from the low part.
- start while busy or in DONE is ignored and does not queue.
- Exact mode, ITER ≥ DATA_W: |y − x·z| ≤ |x|. The result is exact whenever the residual reaches 0.
- approx_en only affects accumulator additions; the zr arithmetic is always exact.

## Timing
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, y=0, iters=0, acc=0, zr=0, i=0. Reset mid-RUN aborts the operation and produces no done.
- Let E0 be the edge that accepts start and n the number of iterations performed. busy is high from after E0 until edge E0+n+1. done and the new y/iters are valid in the cycle after edge E0+n+1.
- Latency: n+1 cycles, minimum 1 (z=0), maximum ITER+1.
- Next start is accepted at the earliest 2 edges after done rises (the DONE cycle, then IDLE).
- busy and done are never high simultaneously.

## Test plan
- Reset, then x=100, z=64, approx_en=0 → n=2, done one cycle after edge E0+3, y=6400, iters=2.
- x=1, z=127, exact → n=8, y=127, iters=8, done after edge E0+9. Also x=-128, z=-128 → n=1, y=16384.
- x=5, z=0 → n=0, done after edge E0+1, y=0, iters=0. Hold start=1 continuously and check that the next capture happens only after returning to IDLE.
- x=3, z=127, approx_en=1, APPROX_LSB=4 → y=367, iters=8. The same operands with approx_en=0 → y=381.
- Pulse start with new operands during RUN → ignored, and the original result completes unchanged. Assert rst_n low at E0+3 of an 8-iteration run → all outputs 0 immediately, no done pulse, next operation correct.
- Random exact-mode sweep over all x, z (DATA_W=8, ITER=8) → |y−x·z| ≤ |x|, and done occurs exactly once per accepted start.
